nasti_lite_write_arbiter: RTL and testbench
===========================================

# nasti_lite_write_arbiter

Round-robin arbiter that shares one NASTI-lite write port among `NUM_MASTERS` requesters. Typically drives the lite side of the NASTI-lite to NASTI write converter. Each write is an AW beat followed by one W beat from the same master, and the arbiter holds the grant for that whole pair. B responses return to the issuing master through index bits prepended to the downstream ID. A per-master outstanding-write limit provides back-pressure.

## Interface
- `NUM_MASTERS`, 2: number of upstream lite masters, ≥ 2.
- `ID_WIDTH`, 1: upstream ID width.
- `ADDR_WIDTH`, 8: address width.
- `DATA_WIDTH`, 32: lite data width, 32 or 64 only; any other value triggers `$fatal`.
- `USER_WIDTH`, 1: user field width, > 0.
- `MAX_OUTSTANDING`, 4: maximum issued-but-unacknowledged writes per master, ≥ 1.
- Derived widths:
  - MI = $clog2(NUM_MASTERS)
  - AW = ID_WIDTH+ADDR_WIDTH+11+USER_WIDTH, packed {id, addr, prot[2:0], qos[3:0], region[3:0], user}
  - WW = DATA_WIDTH+DATA_WIDTH/8+USER_WIDTH, packed {data, strb, user}
  - BW = ID_WIDTH+2+USER_WIDTH, packed {id, resp, user}
- Ports (master m occupies slice m of each packed vector):
  - `clk`  in  1  sole clock, rising edge.
  - `rst`  in  1  synchronous, active-high reset.
  - `m_aw_payload`  in  NUM_MASTERS*AW  per-master AW fields.
  - `m_aw_valid`  in  NUM_MASTERS  per-master AW valid.
  - `m_aw_ready`  out  NUM_MASTERS  per-master AW ready.
  - `m_w_payload`  in  NUM_MASTERS*WW  per-master W fields.
  - `m_w_valid`  in  NUM_MASTERS  per-master W valid.
  - `m_w_ready`  out  NUM_MASTERS  per-master W ready.
  - `m_b_payload`  out  NUM_MASTERS*BW  B fields, broadcast to all slices; id has the index bits stripped.
  - `m_b_valid`  out  NUM_MASTERS  per-master B valid.
  - `m_b_ready`  in  NUM_MASTERS  per-master B ready.
  - `s_aw_payload`  out  MI+AW  {granted index, granted master's AW fields}.
  - `s_aw_valid`  out  1  downstream AW valid.
  - `s_aw_ready`  in  1  downstream AW ready.
  - `s_w_payload`  out  WW  granted master's W fields.
  - `s_w_valid`  out  1  downstream W valid.
  - `s_w_ready`  in  1  downstream W ready.
  - `s_b_payload`  in  MI+BW  {index, id, resp, user}.
  - `s_b_valid`  in  1  downstream B valid.
  - `s_b_ready`  out  1  downstream B ready.

## Operation
- State machine states: IDLE, ADDR, DATA.
- Registered state: `grant` (MI bits), `rr_ptr` (MI bits), `cnt[m]` ($clog2(MAX_OUTSTANDING+1) bits each).
- Eligibility: master m is eligible when m_aw_valid[m] && cnt[m] < MAX_OUTSTANDING.
- IDLE:
  - If any master is eligible, select the first eligible index searching rr_ptr, rr_ptr+1, … modulo NUM_MASTERS.
  - Register that index in `grant` and go to ADDR.
  - Otherwise stay in IDLE.
- ADDR:
  - s_aw_valid = m_aw_valid[grant]; m_aw_ready[grant] = s_aw_ready.
  - s_aw_payload = {grant, m_aw_payload[grant]}.
  - On s_aw handshake: cnt[grant]++ and go to DATA.
- DATA:
  - s_w_valid = m_w_valid[grant]; m_w_ready[grant] = s_w_ready; s_w_payload = m_w_payload[grant].
  - On s_w handshake: rr_ptr ← grant+1 (wraps to 0 at NUM_MASTERS), go to IDLE.
- All ready outputs for non-granted masters are 0; no AW or W is accepted outside its state.
- B routing (combinational, independent of the state machine):
  - idx = s_b_payload[MSB -: MI].
  - If idx < NUM_MASTERS: m_b_valid[idx] = s_b_valid; s_b_ready = m_b_ready[idx].
  - If idx ≥ NUM_MASTERS: s_b_ready = 1 and the beat is discarded.
- Counters:
  - A B handshake to master m decrements cnt[m].
  - An AW and a B handshake on the same master in the same cycle leave cnt unchanged.
  - A B handshake when cnt = 0 is still forwarded; cnt holds at 0 (no underflow).

## Timing
- Reset (rst high at a clock edge): state IDLE, grant 0, rr_ptr 0, all cnt 0.
  - Outputs during and after reset: s_aw_valid, s_w_valid, m_aw_ready, m_w_ready all 0.
  - B path stays combinational: s_b_ready and m_b_valid follow their inputs.
- Reset mid-transfer: the in-flight pair is abandoned immediately. Outstanding counts are lost, and the system is responsible for resetting downstream with the arbiter.
- Latency:
  - AW request → s_aw_valid: 1 cycle (grant is registered).
  - W is forwarded combinationally in DATA, so AW and W complete on different edges.
  - Best-case throughput: one write per 3 cycles.
- Grant is sticky: a master that drops aw_valid while in ADDR keeps the grant, and the state machine waits (protocol violation, not recovered).
- B path has zero latency.

## Test plan
- Single master, NUM_MASTERS=2: m0 presents AW addr 0x10 and W data 0xDEADBEEF strb 0xF.
  - s_aw_valid one cycle after the request, with index 0 in the MSBs.
  - Next cycle s_w carries 0xDEADBEEF; cnt[0] = 1.
  - B {idx 0, resp 0} reaches m_b_valid[0] only; cnt[0] = 0.
- Fairness: both masters request continuously for 6 writes → grant order 0,1,0,1,0,1; no AW of either master between another master's AW and W.
- Outstanding cap, MAX_OUTSTANDING=2, B held off:
  - m0's third AW is not granted while m1 still completes writes.
  - Releasing one B for m0 lets its third AW grant within 2 cycles.
- Simultaneous AW handshake and B handshake on m1 → cnt[1] unchanged.
- B back-pressure: s_b_valid with idx 1 while m_b_ready[1]=0 → s_b_ready=0 until m_b_ready[1]=1. NUM_MASTERS=3 with idx 3 → s_b_ready=1, no m_b_valid bit set.
- Reset asserted in DATA with s_w_ready=0 → next cycle all valids/readies 0, state IDLE, rr_ptr 0; a subsequent write from m1 completes normally.

Source files
------------

// File: rtl/nasti_lite_write_arbiter_if.sv
// nasti_lite_write_arbiter_if: upstream per-master and downstream shared NASTI-lite write channels.
// Master m occupies slice m of every packed m_* vector.
interface nasti_lite_write_arbiter_if #(
    parameter int NUM_MASTERS = 2,
    parameter int ID_WIDTH    = 1,
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int USER_WIDTH  = 1
);
    localparam int MI = $clog2(NUM_MASTERS);
    localparam int AW = ID_WIDTH + ADDR_WIDTH + 11 + USER_WIDTH;
    localparam int WW = DATA_WIDTH + DATA_WIDTH / 8 + USER_WIDTH;
    localparam int BW = ID_WIDTH + 2 + USER_WIDTH;

    logic [NUM_MASTERS*AW-1:0] m_aw_payload;
    logic [NUM_MASTERS-1:0]    m_aw_valid;
    logic [NUM_MASTERS-1:0]    m_aw_ready;
    logic [NUM_MASTERS*WW-1:0] m_w_payload;
    logic [NUM_MASTERS-1:0]    m_w_valid;
    logic [NUM_MASTERS-1:0]    m_w_ready;
    logic [NUM_MASTERS*BW-1:0] m_b_payload;
    logic [NUM_MASTERS-1:0]    m_b_valid;
    logic [NUM_MASTERS-1:0]    m_b_ready;
    logic [MI+AW-1:0]          s_aw_payload;
    logic                      s_aw_valid;
    logic                      s_aw_ready;
    logic [WW-1:0]             s_w_payload;
    logic                      s_w_valid;
    logic                      s_w_ready;
    logic [MI+BW-1:0]          s_b_payload;
    logic                      s_b_valid;
    logic                      s_b_ready;

    modport slave (
        input  m_aw_payload, m_aw_valid, m_w_payload, m_w_valid, m_b_ready,
        output m_aw_ready, m_w_ready, m_b_payload, m_b_valid,
        output s_aw_payload, s_aw_valid, s_w_payload, s_w_valid, s_b_ready,
        input  s_aw_ready, s_w_ready, s_b_payload, s_b_valid
    );

    modport master (
        output m_aw_payload, m_aw_valid, m_w_payload, m_w_valid, m_b_ready,
        input  m_aw_ready, m_w_ready, m_b_payload, m_b_valid,
        input  s_aw_payload, s_aw_valid, s_w_payload, s_w_valid, s_b_ready,
        output s_aw_ready, s_w_ready, s_b_payload, s_b_valid
    );
endinterface

// File: rtl/nasti_lite_write_arbiter.sv
// nasti_lite_write_arbiter: round-robin sharing of one NASTI-lite write port, AW+W held as a pair,
// B routed back by index bits prepended to the downstream ID, per-master outstanding-write cap.
module nasti_lite_write_arbiter #(
    parameter int NUM_MASTERS     = 2,
    parameter int ID_WIDTH        = 1,
    parameter int ADDR_WIDTH      = 8,
    parameter int DATA_WIDTH      = 32,
    parameter int USER_WIDTH      = 1,
    parameter int MAX_OUTSTANDING = 4
) (
    input logic clk,
    input logic rst,
    nasti_lite_write_arbiter_if.slave bus
);
    localparam int MI = $clog2(NUM_MASTERS);
    localparam int AW = ID_WIDTH + ADDR_WIDTH + 11 + USER_WIDTH;
    localparam int WW = DATA_WIDTH + DATA_WIDTH / 8 + USER_WIDTH;
    localparam int BW = ID_WIDTH + 2 + USER_WIDTH;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
        $fatal(1, "nasti_lite_write_arbiter: DATA_WIDTH must be 32 or 64");
    end

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t                 r_state;
    logic [MI-1:0]          r_grant;
    logic [MI-1:0]          r_rr_ptr;
    logic [CW-1:0]          r_cnt [NUM_MASTERS];
    logic [NUM_MASTERS-1:0] w_elig;
    logic [NUM_MASTERS-1:0] w_b_hs;
    logic [MI-1:0]          w_pick;
    logic [MI-1:0]          w_b_idx;
    logic                   w_found;
    logic                   w_addr;
    logic                   w_data;
    logic                   w_aw_hs;
    logic                   w_w_hs;
    logic                   w_b_ok;

    // Channel enables are masked by rst so nothing leaks while reset is held.
    assign w_addr = !rst && r_state == ADDR;
    assign w_data = !rst && r_state == DATA;

    assign bus.s_aw_valid   = w_addr && bus.m_aw_valid[r_grant];
    assign bus.s_aw_payload = {r_grant, bus.m_aw_payload[r_grant*AW +: AW]};
    assign bus.s_w_valid    = w_data && bus.m_w_valid[r_grant];
    assign bus.s_w_payload  = bus.m_w_payload[r_grant*WW +: WW];
    assign w_aw_hs          = bus.s_aw_valid && bus.s_aw_ready;
    assign w_w_hs           = bus.s_w_valid && bus.s_w_ready;

    // Out-of-range indices are swallowed so a stray response cannot stall the downstream port.
    assign w_b_idx          = bus.s_b_payload[MI+BW-1 -: MI];
    assign w_b_ok           = {1'b0, w_b_idx} < (MI+1)'(NUM_MASTERS);
    assign bus.s_b_ready    = w_b_ok ? bus.m_b_ready[w_b_idx] : 1'b1;
    assign bus.m_b_payload  = {NUM_MASTERS{bus.s_b_payload[BW-1:0]}};
    assign w_b_hs           = bus.m_b_valid & bus.m_b_ready;

    genvar i;
    for (i = 0; i < NUM_MASTERS; i++) begin : g_elig
        assign w_elig[i] = bus.m_aw_valid[i] && r_cnt[i] < CW'(MAX_OUTSTANDING);
    end

    always_comb begin
        bus.m_aw_ready = '0;
        bus.m_w_ready  = '0;
        bus.m_b_valid  = '0;
        bus.m_aw_ready[r_grant] = w_addr && bus.s_aw_ready;
        bus.m_w_ready[r_grant]  = w_data && bus.s_w_ready;
        if (w_b_ok) bus.m_b_valid[w_b_idx] = bus.s_b_valid;
    end

    always_comb begin
        w_found = 1'b0;
        w_pick  = r_rr_ptr;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (!w_found && w_elig[(int'(r_rr_ptr) + k) % NUM_MASTERS]) begin
                w_found = 1'b1;
                w_pick  = MI'((int'(r_rr_ptr) + k) % NUM_MASTERS);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_grant  <= '0;
            r_rr_ptr <= '0;
            for (int k = 0; k < NUM_MASTERS; k++) r_cnt[k] <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_found) begin
                    r_grant <= w_pick;
                    r_state <= ADDR;
                end
                ADDR: if (w_aw_hs) r_state <= DATA;
                DATA: if (w_w_hs) begin
                    r_rr_ptr <= (r_grant == MI'(NUM_MASTERS - 1)) ? '0 : r_grant + 1'b1;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
            // Simultaneous issue and response cancel; a response at zero saturates.
            for (int k = 0; k < NUM_MASTERS; k++) begin
                if (w_aw_hs && r_grant == MI'(k) && !w_b_hs[k])
                    r_cnt[k] <= r_cnt[k] + 1'b1;
                else if (w_b_hs[k] && !(w_aw_hs && r_grant == MI'(k)) && r_cnt[k] != '0)
                    r_cnt[k] <= r_cnt[k] - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_nasti_lite_write_arbiter.sv
// tb_nasti_lite_write_arbiter: B-routing vector table plus write sequences checked by AW/W scoreboards,
// on a 2-master (cap 4) and a 3-master (cap 2) instance.
`timescale 1ns/1ps
module tb_nasti_lite_write_arbiter;
    localparam int AW = 21;
    localparam int WW = 37;

    typedef struct {
        logic       idx;
        logic       bv;
        logic [1:0] mr;
        logic [1:0] emv;
        logic       esr;
    } bvec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    bit   in_w = 1'b0;
    logic [AW:0]   aw_qa[$];
    logic [WW-1:0] w_qa[$];
    logic [AW+1:0] aw_qb[$];

    always #5 clk = ~clk;

    nasti_lite_write_arbiter_if #(.NUM_MASTERS(2)) ia ();
    nasti_lite_write_arbiter_if #(.NUM_MASTERS(3)) ib ();

    nasti_lite_write_arbiter #(.NUM_MASTERS(2), .MAX_OUTSTANDING(4)) dut_a (.clk(clk), .rst(rst), .bus(ia));
    nasti_lite_write_arbiter #(.NUM_MASTERS(3), .MAX_OUTSTANDING(2)) dut_b (.clk(clk), .rst(rst), .bus(ib));

    function automatic logic [AW-1:0] mk_aw(input logic id, input logic [7:0] a);
        return {id, a, 3'b010, 4'h0, 4'h0, 1'b1};
    endfunction

    function automatic logic [WW-1:0] mk_w(input logic [31:0] d, input logic [3:0] s);
        return {d, s, 1'b0};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    task automatic expire(input string nm);
        total++;
        bad++;
        $display("FAIL %s: got no handshake within bound, required one", nm);
    endtask

    task automatic unexpected(input string nm);
        total++;
        bad++;
        $display("FAIL %s: got a handshake, required none pending", nm);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic wr_a(input int m, input logic [AW-1:0] aw, input logic [WW-1:0] w);
        int n = 0;
        ia.m_aw_payload[m*AW +: AW] = aw;
        ia.m_aw_valid[m] = 1'b1;
        do begin @(negedge clk); n++; end while (!ia.m_aw_ready[m] && n < 100);
        if (n >= 100) expire("wr_a_aw");
        tick();
        ia.m_aw_valid[m] = 1'b0;
        ia.m_w_payload[m*WW +: WW] = w;
        ia.m_w_valid[m] = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!ia.m_w_ready[m] && n < 100);
        if (n >= 100) expire("wr_a_w");
        tick();
        ia.m_w_valid[m] = 1'b0;
    endtask

    task automatic wr_b(input int m, input logic [AW-1:0] aw, input logic [WW-1:0] w);
        int n = 0;
        ib.m_aw_payload[m*AW +: AW] = aw;
        ib.m_aw_valid[m] = 1'b1;
        do begin @(negedge clk); n++; end while (!ib.m_aw_ready[m] && n < 100);
        if (n >= 100) expire("wr_b_aw");
        tick();
        ib.m_aw_valid[m] = 1'b0;
        ib.m_w_payload[m*WW +: WW] = w;
        ib.m_w_valid[m] = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!ib.m_w_ready[m] && n < 100);
        if (n >= 100) expire("wr_b_w");
        tick();
        ib.m_w_valid[m] = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst) in_w = 1'b0;
        else begin
            if (ia.s_aw_valid && ia.s_aw_ready) begin
                chk("aw_inside_pair", in_w, 0);
                in_w = 1'b1;
                if (aw_qa.size() == 0) unexpected("s_aw_a");
                else chk("s_aw_a", ia.s_aw_payload, aw_qa.pop_front());
            end
            if (ia.s_w_valid && ia.s_w_ready) begin
                chk("w_outside_pair", in_w, 1);
                in_w = 1'b0;
                if (w_qa.size() == 0) unexpected("s_w_a");
                else chk("s_w_a", ia.s_w_payload, w_qa.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && ib.s_aw_valid && ib.s_aw_ready) begin
            if (aw_qb.size() == 0) unexpected("s_aw_b");
            else chk("s_aw_b", ib.s_aw_payload, aw_qb.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, required one");
        $fatal(1, "watchdog");
    end

    initial begin
        bvec_t tv[6];
        int n;
        tv[0] = '{1'b0, 1'b1, 2'b01, 2'b01, 1'b1};
        tv[1] = '{1'b1, 1'b1, 2'b00, 2'b10, 1'b0};
        tv[2] = '{1'b1, 1'b1, 2'b10, 2'b10, 1'b1};
        tv[3] = '{1'b0, 1'b0, 2'b00, 2'b00, 1'b0};
        tv[4] = '{1'b1, 1'b0, 2'b10, 2'b00, 1'b1};
        tv[5] = '{1'b0, 1'b1, 2'b10, 2'b01, 1'b0};
        ia.m_aw_payload = '0; ia.m_aw_valid = '0; ia.m_w_payload = '0; ia.m_w_valid = '0;
        ia.m_b_ready = '0; ia.s_aw_ready = 1'b1; ia.s_w_ready = 1'b1; ia.s_b_payload = '0; ia.s_b_valid = 1'b0;
        ib.m_aw_payload = '0; ib.m_aw_valid = '0; ib.m_w_payload = '0; ib.m_w_valid = '0;
        ib.m_b_ready = '0; ib.s_aw_ready = 1'b1; ib.s_w_ready = 1'b1; ib.s_b_payload = '0; ib.s_b_valid = 1'b0;

        // Held in reset with requests present: handshake outputs stay low, B path still live.
        tick();
        ia.m_aw_valid = 2'b11; ia.m_w_valid = 2'b11;
        ia.s_b_payload = {1'b1, 4'b0000}; ia.s_b_valid = 1'b1; ia.m_b_ready = 2'b10;
        #1;
        chk("rst_hs_outputs", {ia.s_aw_valid, ia.s_w_valid, ia.m_aw_ready, ia.m_w_ready}, 0);
        chk("rst_b_valid", ia.m_b_valid, 2'b10);
        chk("rst_b_ready", ia.s_b_ready, 1);
        ia.m_aw_valid = '0; ia.m_w_valid = '0; ia.s_b_valid = 1'b0; ia.m_b_ready = '0;
        tick();
        rst = 1'b0;
        chk("rst_cnt0", dut_a.r_cnt[0], 0);

        foreach (tv[i]) begin
            ia.s_b_payload = {tv[i].idx, 1'b1, 2'b10, 1'b0};
            ia.s_b_valid = tv[i].bv;
            ia.m_b_ready = tv[i].mr;
            #1;
            chk($sformatf("bvec%0d_valid", i), ia.m_b_valid, tv[i].emv);
            chk($sformatf("bvec%0d_ready", i), ia.s_b_ready, tv[i].esr);
            chk($sformatf("bvec%0d_payload", i), ia.m_b_payload, 8'hCC);
        end
        ia.s_b_valid = 1'b0; ia.m_b_ready = '0;
        tick();
        chk("b_at_zero_cnt0", dut_a.r_cnt[0], 0);
        chk("b_at_zero_cnt1", dut_a.r_cnt[1], 0);

        // Single write from m0, then its response.
        aw_qa.push_back({1'b0, mk_aw(1'b0, 8'h10)});
        w_qa.push_back(mk_w(32'hDEADBEEF, 4'hF));
        fork
            wr_a(0, mk_aw(1'b0, 8'h10), mk_w(32'hDEADBEEF, 4'hF));
            begin
                @(negedge clk); chk("lat_aw_early", ia.s_aw_valid, 0);
                @(negedge clk); chk("lat_aw_one", ia.s_aw_valid, 1);
                @(negedge clk); chk("w_next_cycle", ia.s_w_valid, 1);
                chk("cnt0_after_aw", dut_a.r_cnt[0], 1);
            end
        join
        ia.s_b_payload = {1'b0, 1'b0, 2'b00, 1'b0}; ia.s_b_valid = 1'b1; ia.m_b_ready = 2'b11;
        #1;
        chk("b_route_m0", ia.m_b_valid, 2'b01);
        tick();
        ia.s_b_valid = 1'b0; ia.m_b_ready = '0;
        chk("cnt0_after_b", dut_a.r_cnt[0], 0);

        // Fairness: both masters request back to back.
        do_reset();
        for (int k = 0; k < 6; k++) begin
            aw_qa.push_back({1'(k % 2), mk_aw(1'(k % 2), 8'(32 + k))});
            w_qa.push_back(mk_w(32'(4096 + k), 4'hF));
        end
        fork
            begin for (int k = 0; k < 6; k += 2) wr_a(0, mk_aw(1'b0, 8'(32 + k)), mk_w(32'(4096 + k), 4'hF)); end
            begin for (int k = 1; k < 6; k += 2) wr_a(1, mk_aw(1'b1, 8'(32 + k)), mk_w(32'(4096 + k), 4'hF)); end
        join
        chk("fair_aw_drained", aw_qa.size(), 0);
        chk("fair_w_drained", w_qa.size(), 0);
        chk("fair_cnt0", dut_a.r_cnt[0], 3);
        chk("fair_cnt1", dut_a.r_cnt[1], 3);

        // AW and B handshakes for m1 on the same edge.
        ia.s_aw_ready = 1'b0;
        aw_qa.push_back({1'b1, mk_aw(1'b1, 8'h55)});
        w_qa.push_back(mk_w(32'h55, 4'h3));
        fork
            wr_a(1, mk_aw(1'b1, 8'h55), mk_w(32'h55, 4'h3));
            begin
                n = 0;
                do begin @(negedge clk); n++; end while (!ia.s_aw_valid && n < 20);
                if (n >= 20) expire("same_edge_addr");
                tick();
                ia.s_aw_ready = 1'b1;
                ia.s_b_payload = {1'b1, 1'b1, 2'b01, 1'b0}; ia.s_b_valid = 1'b1; ia.m_b_ready = 2'b10;
                tick();
                ia.s_b_valid = 1'b0; ia.m_b_ready = '0;
                chk("same_edge_cnt1", dut_a.r_cnt[1], 3);
                chk("same_edge_cnt0", dut_a.r_cnt[0], 3);
            end
        join

        // Reset while m1's W is stalled; rr_ptr is 1 going in.
        aw_qa.push_back({1'b0, mk_aw(1'b0, 8'h66)});
        w_qa.push_back(mk_w(32'h66, 4'hF));
        wr_a(0, mk_aw(1'b0, 8'h66), mk_w(32'h66, 4'hF));
        aw_qa.push_back({1'b1, mk_aw(1'b1, 8'h77)});
        ia.s_w_ready = 1'b0;
        ia.m_aw_payload[AW +: AW] = mk_aw(1'b1, 8'h77);
        ia.m_aw_valid[1] = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!ia.m_aw_ready[1] && n < 20);
        if (n >= 20) expire("rst_test_aw");
        tick();
        ia.m_aw_valid[1] = 1'b0;
        ia.m_w_payload[WW +: WW] = mk_w(32'h77, 4'hF);
        ia.m_w_valid[1] = 1'b1;
        @(negedge clk);
        chk("stall_in_data", ia.s_w_valid, 1);
        rst = 1'b1;
        #1;
        chk("rst_mid_w_valid", ia.s_w_valid, 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_outputs", {ia.s_aw_valid, ia.s_w_valid, ia.m_aw_ready, ia.m_w_ready}, 0);
        chk("post_rst_cnt0", dut_a.r_cnt[0], 0);
        chk("post_rst_cnt1", dut_a.r_cnt[1], 0);
        ia.m_w_valid[1] = 1'b0;
        ia.s_w_ready = 1'b1;
        tick();
        aw_qa.push_back({1'b0, mk_aw(1'b0, 8'h88)});
        aw_qa.push_back({1'b1, mk_aw(1'b1, 8'h99)});
        w_qa.push_back(mk_w(32'h88, 4'hF));
        w_qa.push_back(mk_w(32'h99, 4'h1));
        fork
            wr_a(0, mk_aw(1'b0, 8'h88), mk_w(32'h88, 4'hF));
            wr_a(1, mk_aw(1'b1, 8'h99), mk_w(32'h99, 4'h1));
        join
        chk("a_aw_drained", aw_qa.size(), 0);
        chk("a_w_drained", w_qa.size(), 0);

        // Outstanding cap of 2 on the 3-master instance, responses held off.
        do_reset();
        aw_qb.push_back({2'd0, mk_aw(1'b0, 8'h80)});
        aw_qb.push_back({2'd0, mk_aw(1'b0, 8'h81)});
        wr_b(0, mk_aw(1'b0, 8'h80), mk_w(32'h80, 4'hF));
        wr_b(0, mk_aw(1'b0, 8'h81), mk_w(32'h81, 4'hF));
        aw_qb.push_back({2'd1, mk_aw(1'b1, 8'h90)});
        aw_qb.push_back({2'd1, mk_aw(1'b1, 8'h91)});
        aw_qb.push_back({2'd0, mk_aw(1'b0, 8'h82)});
        fork
            wr_b(0, mk_aw(1'b0, 8'h82), mk_w(32'h82, 4'hF));
            begin
                wr_b(1, mk_aw(1'b1, 8'h90), mk_w(32'h90, 4'hF));
                wr_b(1, mk_aw(1'b1, 8'h91), mk_w(32'h91, 4'hF));
                repeat (3) begin @(negedge clk); chk("cap_hold", ib.s_aw_valid, 0); end
                tick();
                ib.s_b_payload = {2'd0, 4'b0000}; ib.s_b_valid = 1'b1; ib.m_b_ready = 3'b001;
                tick();
                ib.s_b_valid = 1'b0; ib.m_b_ready = '0;
                n = 0;
                do begin @(negedge clk); n++; end while (!ib.s_aw_valid && n < 10);
                chk("cap_release_cycles", n, 2);
            end
        join
        chk("b_aw_drained", aw_qb.size(), 0);

        // Index beyond NUM_MASTERS is absorbed; in-range index backpressures.
        ib.s_b_payload = {2'd3, 4'b0110}; ib.s_b_valid = 1'b1; ib.m_b_ready = 3'b000;
        #1;
        chk("idx3_ready", ib.s_b_ready, 1);
        chk("idx3_valid", ib.m_b_valid, 0);
        ib.s_b_payload = {2'd2, 4'b0110};
        #1;
        chk("idx2_ready", ib.s_b_ready, 0);
        chk("idx2_valid", ib.m_b_valid, 3'b100);
        ib.s_b_valid = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
